// File: rtl/apb_master_fsm.sv
// apb_master_fsm: turns one AXI-Lite front-end command into one APB transfer (IDLE/SETUP/ACCESS/RESP).
// Latency: handshake at edge N -> SETUP N+1, ACCESS N+2, rsp_valid N+3 at the earliest (4 cycles per transaction minimum).
// Backpressure: cmd_ready only in IDLE, response held until rsp_ready; `APB_TIMEOUT_EN adds an ACCESS watchdog.
module apb_master_fsm #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    input  logic [2:0]              cmd_prot,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [2:0]              pprot,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pready,
    input  logic                    pslverr
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  write;
        logic [DATA_WIDTH-1:0] wdata;
        logic [STRB_WIDTH-1:0] strb;
        logic [2:0]            prot;
    } req_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic [1:0]            resp;
    } rsp_t;

    state_t state_q, state_d;
    req_t   req_q, req_d;
    rsp_t   rsp_q, rsp_d;
    logic   psel_q, psel_d;
    logic   penable_q, penable_d;
    logic   cmd_ready_q, cmd_ready_d;
    logic   rsp_valid_q, rsp_valid_d;

`ifdef APB_TIMEOUT_EN
    localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_WIDTH-1:0] TIMER_LIMIT = TIMER_WIDTH'(TIMEOUT_CYCLES);

    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic                   timer_expired;

    assign timer_expired = (timer_q == TIMER_LIMIT);
`endif

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        rsp_d   = rsp_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    req_d.addr  = cmd_addr;
                    req_d.write = cmd_write;
                    req_d.wdata = cmd_wdata;
                    req_d.strb  = cmd_write ? cmd_wstrb : '0;
                    req_d.prot  = cmd_prot;
                    state_d     = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                // prdata/pslverr only mean anything on the completing beat
                if (psel_q && penable_q && pready) begin
                    rsp_d.rdata = req_q.write ? '0 : prdata;
                    rsp_d.resp  = pslverr ? 2'b10 : 2'b00;
                    state_d     = RESP;
                end
`ifdef APB_TIMEOUT_EN
                else if (timer_expired) begin
                    rsp_d.rdata = '0;
                    rsp_d.resp  = 2'b10;
                    state_d     = RESP;
                end
`endif
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they are registered but line up with it.
        psel_d      = (state_d == SETUP) || (state_d == ACCESS);
        penable_d   = (state_d == ACCESS);
        cmd_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
    end

`ifdef APB_TIMEOUT_EN
    always_comb begin
        timer_d = '0;
        if (state_q == ACCESS && state_d == ACCESS) timer_d = timer_q + 1'b1;
    end
`endif

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= IDLE;
            req_q       <= '0;
            rsp_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
`ifdef APB_TIMEOUT_EN
            timer_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            rsp_q       <= rsp_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
`ifdef APB_TIMEOUT_EN
            timer_q     <= timer_d;
`endif
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_q.rdata;
    assign rsp_resp  = rsp_q.resp;
    assign paddr     = req_q.addr;
    assign pwrite    = req_q.write;
    assign pwdata    = req_q.wdata;
    assign pstrb     = req_q.strb;
    assign pprot     = req_q.prot;
    assign psel      = psel_q;
    assign penable   = penable_q;

endmodule

// File: tb/tb_apb_master_fsm.sv
// Bench for apb_master_fsm: acts as the front-end and the APB slave, predicting each transfer's timeline and response.
module tb_apb_master_fsm;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;
`ifdef APB_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic          aclk;
    logic          areset;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_wstrb;
    logic [2:0]    cmd_prot;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic [2:0]    pprot;
    logic          psel, penable, pwrite;
    logic [DW-1:0] prdata;
    logic          pready, pslverr;

    int vectors = 0;
    int miscompares = 0;

    apb_master_fsm #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .aclk(aclk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_req(input string tag, input bit wr, input logic [AW-1:0] addr,
                             input logic [DW-1:0] data, input logic [SW-1:0] strb, input logic [2:0] prot);
        check_eq({tag, "_paddr"}, 64'(paddr), 64'(addr));
        check_eq({tag, "_pwrite"}, 64'(pwrite), 64'(wr));
        check_eq({tag, "_pstrb"}, 64'(pstrb), wr ? 64'(strb) : 64'(0));
        check_eq({tag, "_pprot"}, 64'(pprot), 64'(prot));
        if (wr) check_eq({tag, "_pwdata"}, 64'(pwdata), 64'(data));
    endtask

    // Called at a negedge while the DUT is idle and ready.
    task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [SW-1:0] strb, input logic [2:0] prot, input int waits,
                           input bit err, input logic [DW-1:0] rdval, input int rsp_delay);
        bit            timed_out;
        int            n_wait;
        logic [DW-1:0] exp_rdata;
        logic [1:0]    exp_resp;
        timed_out = TIMEOUT_ON && (waits > TO);
        n_wait    = timed_out ? TO : waits;
        exp_rdata = (timed_out || wr) ? '0 : rdval;
        exp_resp  = (timed_out || err) ? 2'b10 : 2'b00;

        check_eq("idle_cmd_ready", 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
        cmd_wdata = data; cmd_wstrb = strb; cmd_prot = prot;
        @(posedge aclk);
        @(negedge aclk);
        // a different command stays pending upstream and must not disturb this one
        cmd_write = 1'($urandom_range(0, 1)); cmd_addr = $urandom; cmd_wdata = $urandom;
        cmd_wstrb = 4'($urandom_range(0, 15)); cmd_prot = 3'($urandom_range(0, 7));
        check_eq("setup_psel", 64'(psel), 64'(1));
        check_eq("setup_penable", 64'(penable), 64'(0));
        check_eq("setup_cmd_ready", 64'(cmd_ready), 64'(0));
        check_eq("setup_rsp_valid", 64'(rsp_valid), 64'(0));
        check_req("setup", wr, addr, data, strb, prot);
        @(posedge aclk);
        for (int k = 0; k <= n_wait; k++) begin
            @(negedge aclk);
            check_eq("access_psel", 64'(psel), 64'(1));
            check_eq("access_penable", 64'(penable), 64'(1));
            check_eq("access_rsp_valid", 64'(rsp_valid), 64'(0));
            check_req("access", wr, addr, data, strb, prot);
            pready  = !timed_out && (k == n_wait);
            prdata  = pready ? rdval : $urandom;
            pslverr = pready ? err : 1'($urandom_range(0, 1));
            @(posedge aclk);
        end
        @(negedge aclk);
        pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
        for (int d = 0; d <= rsp_delay; d++) begin
            check_eq("resp_rsp_valid", 64'(rsp_valid), 64'(1));
            check_eq("resp_rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
            check_eq("resp_rsp_resp", 64'(rsp_resp), 64'(exp_resp));
            check_eq("resp_psel", 64'(psel), 64'(0));
            check_eq("resp_penable", 64'(penable), 64'(0));
            check_eq("resp_cmd_ready", 64'(cmd_ready), 64'(0));
            rsp_ready = (d == rsp_delay);
            if (d == rsp_delay) cmd_valid = 1'b0;
            @(posedge aclk);
            @(negedge aclk);
        end
        rsp_ready = 1'b0;
        check_eq("done_rsp_valid", 64'(rsp_valid), 64'(0));
        check_eq("done_cmd_ready", 64'(cmd_ready), 64'(1));
        check_eq("done_psel", 64'(psel), 64'(0));
    endtask

    task automatic reset_mid_access();
        check_eq("rst_idle_cmd_ready", 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0044;
        cmd_wdata = 32'hA5A5_5A5A; cmd_wstrb = 4'h3; cmd_prot = 3'b001;
        @(posedge aclk);
        @(negedge aclk);
        cmd_valid = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        check_eq("rst_pre_penable", 64'(penable), 64'(1));
        areset = 1'b1; pready = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        check_eq("rst_psel", 64'(psel), 64'(0));
        check_eq("rst_penable", 64'(penable), 64'(0));
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check_eq("rst_cmd_ready", 64'(cmd_ready), 64'(0));
        check_eq("rst_paddr", 64'(paddr), 64'(0));
        areset = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        check_eq("rst_rel_cmd_ready", 64'(cmd_ready), 64'(1));
        check_eq("rst_rel_rsp_valid", 64'(rsp_valid), 64'(0));
    endtask

    initial begin
        areset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_wstrb = '0; cmd_prot = '0; rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check_eq("reset_cmd_ready", 64'(cmd_ready), 64'(0));
        check_eq("reset_psel", 64'(psel), 64'(0));
        check_eq("reset_penable", 64'(penable), 64'(0));
        check_eq("reset_pwrite", 64'(pwrite), 64'(0));
        check_eq("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        check_eq("reset_paddr", 64'(paddr), 64'(0));
        check_eq("reset_pwdata", 64'(pwdata), 64'(0));
        check_eq("reset_pstrb", 64'(pstrb), 64'(0));
        check_eq("reset_pprot", 64'(pprot), 64'(0));
        check_eq("reset_rsp_rdata", 64'(rsp_rdata), 64'(0));
        check_eq("reset_rsp_resp", 64'(rsp_resp), 64'(0));
        areset = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        check_eq("post_reset_cmd_ready", 64'(cmd_ready), 64'(1));

        run_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'b000, 0, 1'b0, 32'h0, 0);
        run_txn(1'b0, 32'h0000_0020, 32'h0BAD_F00D, 4'hF, 3'b010, 3, 1'b0, 32'h1234_5678, 0);
        run_txn(1'b1, 32'h0000_0030, 32'h0102_0304, 4'h5, 3'b111, 1, 1'b1, 32'h0, 0);
        run_txn(0, 32'h0000_0034, 32'h0, 4'hF, 3'b000, 0, 1'b1, 32'h7777_0000, 0);
        run_txn(1'b0, 32'h0000_0038, 32'h0, 4'hF, 3'b100, 2, 1'b0, 32'h8765_4321, 5);
        run_txn(1'b0, 32'h0000_0040, 32'h0, 4'h0, 3'b000, TO, 1'b0, 32'h5555_AAAA, 0);
        run_txn(1'b1, 32'h0000_0048, 32'hFFFF_0000, 4'hC, 3'b011, TO + 8, 1'b0, 32'h0, 1);
        reset_mid_access();

        for (int i = 0; i < 60; i++) begin
            run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
                    3'($urandom_range(0, 7)), $urandom_range(0, 4), 1'($urandom_range(0, 1)),
                    $urandom, $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge aclk);
                @(negedge aclk);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/apb_master_fsm.md
APB_MASTER_FSM -- requirements
Module: apb_master_fsm

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width of the command and APB paths.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; strobe width is DATA_WIDTH/8.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum ACCESS wait cycles (used only per REQ-027).
REQ-004 SHALL have ports; one clock, reset synchronous active-high:
- aclk  in  1  clock, all logic on the rising edge
- areset  in  1  synchronous active-high reset
- cmd_valid  in  1  command from the AXI-Lite slave front-end is valid
- cmd_ready  out  1  block accepts a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_wstrb  in  DATA_WIDTH/8  write byte strobes
- cmd_prot  in  3  protection bits (from arprot/awprot)
- rsp_valid  out  1  response valid toward the front-end
- rsp_ready  in  1  front-end accepts the response
- rsp_rdata  out  DATA_WIDTH  read data
- rsp_resp  out  2  00 OKAY, 10 SLVERR
- paddr, pwdata  out  ADDR_WIDTH, DATA_WIDTH  APB address and write data
- pstrb  out  DATA_WIDTH/8  APB strobes
- pprot  out  3  APB protection
- psel, penable, pwrite  out  1 each  APB control
- prdata  in  DATA_WIDTH  APB read data
- pready, pslverr  in  1 each  APB completion and error

Function
REQ-005 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-006 cmd_ready SHALL be 1 only in IDLE; a handshake is cmd_valid & cmd_ready at a rising edge.
REQ-007 On handshake, SHALL register cmd_* into paddr/pwrite/pwdata/pstrb/pprot and go to SETUP.
REQ-008 pstrb SHALL be 0 for reads; pwdata don't-care for reads.
REQ-009 SETUP SHALL last exactly one cycle: psel=1, penable=0, then go to ACCESS.
REQ-010 ACCESS: psel=1, penable=1; remain while pready=0.
REQ-011 paddr, pwrite, pwdata, pstrb, pprot SHALL be stable from SETUP through the final ACCESS cycle.
REQ-012 ACCESS with pready=1: capture rsp_rdata = prdata (read) or 0 (write); rsp_resp = pslverr ? 10 : 00; go to RESP.
REQ-013 psel and penable SHALL be 0 in IDLE and RESP; no back-to-back transfer without IDLE.
REQ-014 RESP: rsp_valid=1; rsp_rdata/rsp_resp held stable until rsp_valid & rsp_ready, then IDLE.
REQ-015 rsp_valid SHALL NOT depend combinationally on rsp_ready.
REQ-016 Latency: handshake at edge N → SETUP in cycle N+1, ACCESS N+2, earliest rsp_valid N+3; minimum 4 cycles per transaction.
REQ-017 cmd_valid in non-IDLE states SHALL be ignored; the command stays pending upstream.
REQ-018 pslverr and prdata SHALL be sampled only when psel & penable & pready.

Reset
REQ-019 areset=1 at an edge SHALL force IDLE regardless of state, including mid-ACCESS (APB transfer abandoned, pending response discarded).
REQ-020 Reset values: cmd_ready=0 during reset, 1 on first cycle after; psel=0, penable=0, pwrite=0, rsp_valid=0.
REQ-021 Reset values: paddr, pwdata, pstrb, pprot, rsp_rdata, rsp_resp all 0.
REQ-022 Timeout counter SHALL reset to 0.

Configuration
REQ-023 Macro APB_TIMEOUT_EN SHALL enable an ACCESS-phase watchdog.
REQ-024 With the macro: counter clears on entering ACCESS and increments each ACCESS cycle with pready=0.
REQ-025 With the macro: when the counter reaches TIMEOUT_CYCLES and pready=0, go to RESP with rsp_resp=10, rsp_rdata=0; psel/penable drop next cycle.
REQ-026 With the macro: pready=1 on the same cycle as expiry SHALL win (normal completion).
REQ-027 Without the macro: no counter logic, ACCESS waits indefinitely, TIMEOUT_CYCLES unused.

Verification
REQ-028 Write 0x0000_0010 data 0xDEAD_BEEF strb 0xF, pready=1 in first ACCESS → psel N+1..N+2, penable N+2, rsp_valid N+3, rsp_resp 00.
REQ-029 Read 0x0000_0020, pready after 3 wait cycles, prdata 0x1234_5678 → rsp_rdata 0x1234_5678, resp 00, pstrb 0, paddr stable throughout.
REQ-030 Write with pslverr=1 at pready → rsp_resp 10.
REQ-031 rsp_ready held 0 for 5 cycles → rsp_valid/rsp_rdata stable, cmd_ready 0, psel 0 until handshake.
REQ-032 APB_TIMEOUT_EN, TIMEOUT_CYCLES=16, pready stuck 0 → rsp_resp 10, rsp_rdata 0 after 16 ACCESS wait cycles; without macro, psel stays 1.
REQ-033 areset asserted during ACCESS → next cycle psel=0, penable=0, rsp_valid=0; cmd_ready=1 after release.
